// File: rtl/booth_r4_seq_multiplier.sv
`timescale 1ns / 1ps
// Sequential radix-4 Booth multiplier: one Booth digit retired per CALC cycle, with a
// zero-operand early-out and a valid/ready handshake on both sides.
module booth_r4_seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned EW = WIDTH + 2;
  localparam int unsigned AW = WIDTH + 3;
  localparam int unsigned CW = $clog2(WIDTH / 2 + 2);

  localparam logic [CW-1:0] NSigned   = CW'(WIDTH / 2);
  localparam logic [CW-1:0] NUnsigned = CW'(WIDTH / 2 + 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [EW-1:0]      mreg_q, mreg_d;
  logic               qm1_q, qm1_d;
  logic [EW-1:0]      mcand_q, mcand_d;
  logic               mode_q, mode_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [2:0]         digit;
  logic [AW-1:0]      m1, m2, pp;
  logic [AW-1:0]      acc_sum, acc_sh;
  logic [EW-1:0]      mreg_sh;
  logic [2*WIDTH-1:0] result;

  // Booth digit recoding and one arithmetic shift step of {acc, mreg, qm1}.
  always_comb begin
    digit = {mreg_q[1], mreg_q[0], qm1_q};
    m1    = {mcand_q[EW-1], mcand_q};
    m2    = {mcand_q, 1'b0};
    case (digit)
      3'b001, 3'b010: pp = m1;
      3'b011:         pp = m2;
      3'b100:         pp = -m2;
      3'b101, 3'b110: pp = -m1;
      default:        pp = '0;
    endcase
    acc_sum = acc_q + pp;
    acc_sh  = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
    mreg_sh = {acc_sum[1:0], mreg_q[EW-1:2]};
    // Low product bits have shifted into the top of mreg: W of them when signed, W+2 unsigned.
    if (mode_q) begin
      result = {acc_sh[WIDTH-1:0], mreg_sh[WIDTH+1:2]};
    end else begin
      result = {acc_sh[WIDTH-3:0], mreg_sh};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mreg_d    = mreg_q;
    qm1_d     = qm1_q;
    mcand_d   = mcand_q;
    mode_d    = mode_q;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mode_d  = signed_mode;
          mcand_d = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                : {2'b00, multiplicand};
          mreg_d  = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                : {2'b00, multiplier};
          qm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = signed_mode ? NSigned : NUnsigned;
          if (multiplicand == '0 || multiplier == '0) begin
            product_d = '0;
            state_d   = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d  = acc_sh;
        mreg_d = mreg_sh;
        qm1_d  = mreg_q[1];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          product_d = result;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mreg_q    <= '0;
      qm1_q     <= 1'b0;
      mcand_q   <= '0;
      mode_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mreg_q    <= mreg_d;
      qm1_q     <= qm1_d;
      mcand_q   <= mcand_d;
      mode_q    <= mode_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign product   = product_q;

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
`timescale 1ns / 1ps
// Scoreboard bench for booth_r4_seq_multiplier: directed corner cases at WIDTH=16, then random
// traffic on a WIDTH=16 and a WIDTH=8 instance in parallel against a plain-arithmetic model.
module tb_booth_r4_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv  [2];
  logic        ir  [2];
  logic        sm  [2];
  logic        ov  [2];
  logic        orr [2];
  logic        bz  [2];
  logic [15:0] ma  [2];
  logic [15:0] mb  [2];
  logic [31:0] pr  [2];
  logic [15:0] p8;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  booth_r4_seq_multiplier #(.WIDTH(16)) u_dut16 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (iv[0]),
    .in_ready     (ir[0]),
    .signed_mode  (sm[0]),
    .multiplicand (ma[0]),
    .multiplier   (mb[0]),
    .out_valid    (ov[0]),
    .out_ready    (orr[0]),
    .product      (pr[0]),
    .busy         (bz[0])
  );

  booth_r4_seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (iv[1]),
    .in_ready     (ir[1]),
    .signed_mode  (sm[1]),
    .multiplicand (ma[1][7:0]),
    .multiplier   (mb[1][7:0]),
    .out_valid    (ov[1]),
    .out_ready    (orr[1]),
    .product      (p8),
    .busy         (bz[1])
  );

  assign pr[1] = {16'h0000, p8};

  // Exact product of two w-bit operands, reduced to 2w bits.
  function automatic logic [31:0] ref_mul(input int w, input bit s, input logic [15:0] a,
                                          input logic [15:0] b);
    longint      sa, sb, p;
    logic [63:0] m;
    sa = longint'({48'h0, a});
    sb = longint'({48'h0, b});
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    m = (64'd1 << (2 * w)) - 64'd1;
    return 32'(64'(p) & m);
  endfunction

  function automatic logic [15:0] pick(input int w);
    case ($urandom_range(0, 9))
      0:       return 16'h0000;
      1:       return 16'(32'd1 << (w - 1));
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic monitor(input int d);
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (ov[d] && orr[d]) begin
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          n_tests++;
          n_fail++;
          $display("FAIL product_w%0d: got 0x%0h, expected no transaction", d == 0 ? 16 : 8,
                   pr[d]);
        end else begin
          e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check($sformatf("product_w%0d", d == 0 ? 16 : 8), 64'(pr[d]), 64'(e));
        end
      end
    end
  endtask

  task automatic run_op(input int d, input bit s, input logic [15:0] a_in,
                        input logic [15:0] b_in, input int stall);
    int          w, n, lat, waitc;
    logic [15:0] a, b, mask;
    logic [31:0] e, held;
    w    = (d == 0) ? 16 : 8;
    mask = (d == 0) ? 16'hFFFF : 16'h00FF;
    a    = a_in & mask;
    b    = b_in & mask;
    e    = ref_mul(w, s, a, b);
    n    = s ? w / 2 : w / 2 + 1;
    waitc = 0;
    while (!ir[d] && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("in_ready_before_issue", 64'(ir[d]), 64'd1);
    sm[d] = s;
    ma[d] = a;
    mb[d] = b;
    iv[d] = 1'b1;
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    @(posedge clk); #1;
    // Scramble the inputs: the captured copy must be the one used.
    iv[d] = 1'b0;
    ma[d] = 16'($urandom);
    mb[d] = 16'($urandom);
    sm[d] = 1'($urandom);
    lat = 1;
    while (!ov[d] && lat < 40) begin
      orr[d] = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    orr[d] = 1'b0;
    check($sformatf("latency_w%0d", w), 64'(lat), (a == 0 || b == 0) ? 64'd1 : 64'(n + 1));
    held = pr[d];
    repeat (stall) begin
      iv[d] = 1'($urandom);
      @(posedge clk); #1;
      check("stall_out_valid", 64'(ov[d]), 64'd1);
      check("stall_product", 64'(pr[d]), 64'(held));
      check("stall_in_ready", 64'(ir[d]), 64'd0);
    end
    orr[d] = 1'b1;
    iv[d]  = 1'($urandom);
    @(posedge clk); #1;
    orr[d] = 1'b0;
    iv[d]  = 1'b0;
    check("idle_in_ready", 64'(ir[d]), 64'd1);
    check("idle_out_valid", 64'(ov[d]), 64'd0);
    check("idle_product_hold", 64'(pr[d]), 64'(e));
  endtask

  task automatic rand_ops(input int d, input int count);
    int w, stall;
    w = (d == 0) ? 16 : 8;
    for (int i = 0; i < count; i++) begin
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(d, 1'($urandom), pick(w), pick(w), stall);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i]  = 1'b0;
      orr[i] = 1'b0;
      sm[i]  = 1'b0;
      ma[i]  = '0;
      mb[i]  = '0;
    end
    fork
      monitor(0);
      monitor(1);
      begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_in_ready", 64'(ir[i]), 64'd1);
      check("reset_out_valid", 64'(ov[i]), 64'd0);
      check("reset_busy", 64'(bz[i]), 64'd0);
      check("reset_product", 64'(pr[i]), 64'd0);
    end
    rst = 1'b1;

    run_op(0, 1'b1, 16'h8000, 16'h8000, 0);
    check("signed_minneg_square", 64'(pr[0]), 64'h4000_0000);
    run_op(0, 1'b0, 16'hFFFF, 16'hFFFF, 0);
    check("unsigned_max_square", 64'(pr[0]), 64'hFFFE_0001);
    run_op(0, 1'b1, 16'hFFFF, 16'h0001, 0);
    check("signed_minus_one", 64'(pr[0]), 64'hFFFF_FFFF);
    run_op(0, 1'b0, 16'hFFFF, 16'h0001, 0);
    check("unsigned_ffff_times_one", 64'(pr[0]), 64'h0000_FFFF);
    run_op(0, 1'b1, 16'h1234, 16'h0000, 0);
    check("early_out_zero", 64'(pr[0]), 64'd0);
    run_op(0, 1'b1, 16'h7ABC, 16'hC3D1, 5);

    // Abort a multiply in its fourth CALC cycle.
    sm[0] = 1'b1;
    ma[0] = 16'h1234;
    mb[0] = 16'h5678;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_busy_before", 64'(bz[0]), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort_busy", 64'(bz[0]), 64'd0);
    check("abort_in_ready", 64'(ir[0]), 64'd1);
    check("abort_out_valid", 64'(ov[0]), 64'd0);
    check("abort_product", 64'(pr[0]), 64'd0);
    run_op(0, 1'b1, 16'd3, 16'd5, 0);
    check("post_abort_3x5", 64'(pr[0]), 64'd15);

    fork
      rand_ops(0, 4000);
      rand_ops(1, 6000);
    join

    repeat (4) @(posedge clk);
    check("queue_w16_drained", 64'(exp_q0.size()), 64'd0);
    check("queue_w8_drained", 64'(exp_q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_multiplier.md
BOOTH_R4_SEQ_MULTIPLIER -- requirements
Module: booth_r4_seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving operand width in bits; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operands and mode are presented.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port multiplicand, input, WIDTH bits.
REQ-008 SHALL have port multiplier, input, WIDTH bits.
REQ-009 SHALL have port out_valid, output, 1 bit: product is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the product.
REQ-011 SHALL have port product, output, 2*WIDTH bits: result, signed or unsigned per the captured mode.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 A handshake (in_valid & in_ready) SHALL capture both operands and signed_mode in the same cycle; later input changes SHALL have no effect until the next accept.
REQ-016 Captured operands SHALL be extended to WIDTH+2 bits: sign-extended when signed_mode=1, zero-extended when signed_mode=0.
REQ-017 The partial-product accumulator SHALL be WIDTH+3 bits wide, so that +/-2M never overflows.
REQ-018 Each CALC cycle SHALL retire one radix-4 Booth digit:
- examine multiplier bits {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0;
- add 0, +M, +2M, -2M or -M to the accumulator;
- arithmetic-shift the accumulator/multiplier register right by 2.
REQ-019 CALC SHALL last N cycles: N = WIDTH/2 when signed, N = WIDTH/2+1 when unsigned. An iteration counter SHALL load N on accept and decrement once per CALC cycle.
REQ-020 When the counter reaches its final iteration, the FSM SHALL move CALC -> DONE.
REQ-021 On entering DONE, product SHALL be loaded with the low 2*WIDTH bits of the exact result.
REQ-022 Zero early-out: if the captured multiplicand or multiplier is 0, the FSM SHALL go IDLE -> DONE directly, product = 0, out_valid on the cycle after accept.
REQ-023 Latency, non-zero operands: out_valid SHALL rise N+1 cycles after the accept edge (the accept cycle plus N CALC cycles).
REQ-024 In DONE, product and out_valid SHALL hold stable until out_ready=1.
REQ-025 out_ready=1 in DONE SHALL move the FSM to IDLE on the next edge. No new operand is accepted in that same cycle, so the minimum issue interval is N+2 cycles.
REQ-026 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-027 product SHALL keep its last value in IDLE and CALC; only DONE entry or reset updates it.
REQ-028 Most-negative signed operands (-2^(WIDTH-1)) SHALL produce the exact result with no wrap. For WIDTH=16: (-32768)*(-32768) = 0x40000000.

Reset
REQ-029 While rst=0 at a rising edge, the next state SHALL be:
- FSM = IDLE;
- counter, accumulator and operand registers = 0;
- product = 0, out_valid = 0, busy = 0, in_ready = 1 after the edge.
REQ-030 Reset asserted in CALC or DONE SHALL abort the operation with no out_valid pulse and discard all partial state.
REQ-031 The first accept SHALL be possible on the first edge after rst returns to 1.

Verification
REQ-032 The bench SHALL cover these directed scenarios (WIDTH=16):
- signed, 0x8000 * 0x8000 -> product 0x40000000, out_valid 9 cycles after accept;
- unsigned, 0xFFFF * 0xFFFF -> product 0xFFFE0001, out_valid 10 cycles after accept;
- signed, 0xFFFF * 0x0001 -> product 0xFFFFFFFF; the same operands unsigned -> 0x0000FFFF;
- signed, 0x1234 * 0 -> product 0, out_valid 1 cycle after accept (early-out);
- out_ready held 0 for 5 cycles in DONE -> product and out_valid stable, in_ready 0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, in_ready=1;
- rst=0 in the 4th CALC cycle -> next cycle IDLE, product 0, busy 0, no out_valid; a following 3*5 signed multiply -> product 15.
REQ-033 The bench SHALL also run at least 10,000 random operand/mode pairs at WIDTH=16 and WIDTH=8 with random out_ready stalls, comparing against a behavioural multiply; there SHALL be zero mismatches.
